// File: rtl/pkt_arb_pkg.sv
// rtl/pkt_arb_pkg.sv - shared types, default widths and helpers for the packet tx arbiter
package pkt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_N_PORTS = 4;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_EMPTY_W = 3;
  localparam int DEF_CH_W    = 6;

  // Adds up to 15 events to a 16-bit counter, sticking at all-ones.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/pkt_tx_arbiter_rr_pick.sv
// rtl/pkt_tx_arbiter_rr_pick.sv - combinational round-robin winner select starting after last
module rr_pick #(
  parameter int N_PORTS = 4,
  parameter int IDX_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  always_comb begin
    int unsigned         idx;
    logic [IDX_W-1:0]    cand;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 1; i <= N_PORTS; i++) begin
      idx  = (int'(last) + i) % N_PORTS;
      cand = IDX_W'(idx);
      if (!any && req[cand]) begin
        any    = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_arbiter.sv
// rtl/pkt_tx_arbiter.sv - packet-atomic round-robin merge of N streams onto one registered egress
module pkt_tx_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int EMPTY_W = DEF_EMPTY_W,
  parameter int CH_W    = DEF_CH_W
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [N_PORTS-1:0][DATA_W-1:0]   in_data,
  input  logic [N_PORTS-1:0]               in_valid,
  input  logic [N_PORTS-1:0]               in_sop,
  input  logic [N_PORTS-1:0]               in_eop,
  input  logic [N_PORTS-1:0][EMPTY_W-1:0]  in_empty,
  output logic [N_PORTS-1:0]               in_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_valid,
  output logic                             out_sop,
  output logic                             out_eop,
  output logic [EMPTY_W-1:0]               out_empty,
  output logic [CH_W-1:0]                  out_channel,
  input  logic                             out_ready,
  output logic                             err_orphan,
  output logic [15:0]                      orphan_count
);

  localparam int IDX_W = $clog2(N_PORTS);

  arb_state_e          state_q;
  logic [IDX_W-1:0]    gnt_q, last_q, winner;
  logic                any_req;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q, out_sop_q, out_eop_q;
  logic [EMPTY_W-1:0]  out_empty_q;
  logic [CH_W-1:0]     out_channel_q;
  logic                err_orphan_q;
  logic [15:0]         orphan_count_q, orphan_count_d;
  logic [N_PORTS-1:0]  req, orphan, ready;
  logic [3:0]          orphan_n;
  logic                busy_ready, accept;

  rr_pick #(.N_PORTS(N_PORTS), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  // Ready is forced low while reset is asserted so nothing is taken during reset.
  always_comb begin
    req        = in_valid & in_sop;
    orphan     = in_valid & ~in_sop;
    busy_ready = !out_valid_q || out_ready;
    orphan_n   = '0;
    for (int i = 0; i < N_PORTS; i++) orphan_n = orphan_n + {3'b000, orphan[i]};
    orphan_count_d = sat_add16(orphan_count_q, orphan_n);
    ready = '0;
    if (reset_n) begin
      if (state_q == IDLE) ready = orphan;
      else                 ready[gnt_q] = busy_ready;
    end
    accept = (state_q == BUSY) && in_valid[gnt_q] && busy_ready;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      last_q         <= IDX_W'(N_PORTS - 1);
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_sop_q      <= 1'b0;
      out_eop_q      <= 1'b0;
      out_empty_q    <= '0;
      out_channel_q  <= '0;
      err_orphan_q   <= 1'b0;
      orphan_count_q <= '0;
    end else begin
      err_orphan_q <= 1'b0;
      case (state_q)
        IDLE: begin
          err_orphan_q   <= |orphan;
          orphan_count_q <= orphan_count_d;
          if (any_req) begin
            gnt_q   <= winner;
            last_q  <= winner;
            state_q <= BUSY;
          end
        end
        BUSY:    if (accept && in_eop[gnt_q]) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        out_data_q    <= in_data[gnt_q];
        out_valid_q   <= 1'b1;
        out_sop_q     <= in_sop[gnt_q];
        out_eop_q     <= in_eop[gnt_q];
        out_empty_q   <= in_empty[gnt_q];
        out_channel_q <= CH_W'(gnt_q);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign in_ready     = ready;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_sop      = out_sop_q;
  assign out_eop      = out_eop_q;
  assign out_empty    = out_empty_q;
  assign out_channel  = out_channel_q;
  assign err_orphan   = err_orphan_q;
  assign orphan_count = orphan_count_q;

endmodule

// File: doc/pkt_tx_arbiter.md
# pkt_tx_arbiter

Packet-atomic round-robin arbiter that merges the four per-group Avalon-ST transmit streams of the packet-memory group onto one shared 64-bit egress link. Whole packets are granted one at a time, so beats from different sources never interleave. A source-index channel tag travels with every beat. The output is registered, and the block counts and discards orphan beats (beats arriving outside any packet).

## Interface
Parameters:
- N_PORTS, 4, number of requesting streams (2..8)
- DATA_W, 64, beat width
- EMPTY_W, 3, empty-byte field width
- CH_W, 6, output channel width (must satisfy 2^CH_W >= N_PORTS)

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clock  in  1  sole clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_data[N_PORTS]  in  DATA_W  per-source beat
- in_valid[N_PORTS]  in  1  beat valid
- in_sop[N_PORTS]  in  1  start of packet
- in_eop[N_PORTS]  in  1  end of packet
- in_empty[N_PORTS]  in  EMPTY_W  empty bytes; meaningful only with eop
- in_ready[N_PORTS]  out  1  beat accepted when valid && ready at a rising edge
- out_data  out  DATA_W  egress beat
- out_valid  out  1  egress valid
- out_sop, out_eop  out  1  egress framing
- out_empty  out  EMPTY_W  egress empty count
- out_channel  out  CH_W  index of the source port, zero-extended
- out_ready  in  1  downstream backpressure
- err_orphan  out  1  one-cycle pulse per discarded orphan beat
- orphan_count  out  16  saturating count of discarded beats

## Operation
- The FSM has two states, IDLE and BUSY, plus a registered grant index `gnt` and a round-robin pointer `last`.
- **IDLE:**
  - A port requests when it has in_valid && in_sop.
  - If any port requests, the winner is the first requester scanning from last+1 with wrap-around. On the next edge: gnt <= winner, last <= winner, state <= BUSY.
  - Orphan handling: for every port with in_valid && !in_sop, in_ready = 1. The beat is dropped, err_orphan pulses the following cycle, and orphan_count increments, saturating at 0xFFFF.
  - Multiple orphans in the same cycle add their number to orphan_count, still saturating. err_orphan is a single pulse for that cycle.
- **BUSY:**
  - in_ready[gnt] = !out_valid || out_ready. All other in_ready are 0, and no orphan detection runs.
  - An accepted beat loads the output register, with out_channel = gnt.
  - An accepted beat with eop returns the FSM to IDLE on the same edge.
  - A beat with both sop and eop is a legal one-beat packet.
  - An sop seen mid-packet on the granted port is forwarded unchanged; the block does not police it.
- **Output register:**
  - Loaded on acceptance.
  - out_valid clears when out_ready is high and no new beat is accepted.
  - out_* fields hold stable while out_valid && !out_ready.
- The output register is a single stage with no skid buffer. in_ready depends combinationally on out_ready and out_valid.

## Timing
- **Reset values:**
  - out_valid, out_sop, out_eop, err_orphan: 0
  - out_data, out_empty, out_channel, orphan_count: 0
  - all in_ready: 0
  - state = IDLE, last = N_PORTS-1, so port 0 has priority first
- **Latency:**
  - A request in cycle t is granted at edge t, and in_ready rises in cycle t+1.
  - The first beat is accepted at edge t+1 and visible on out_* in cycle t+2.
- **Throughput:**
  - One beat per cycle within a packet.
  - Exactly one IDLE cycle (no acceptance) between consecutive packets.
- **Simultaneous requests:** the rotation guarantees each waiting port a grant within N_PORTS packets.
- **Reset mid-packet:** the output is cleared immediately and the packet is truncated (no eop is emitted). Downstream must tolerate this.
- **Backpressure:** out_ready low for any number of cycles stalls without loss or duplication.

## Structure
- Package `pkt_arb_pkg`: state enum {IDLE, BUSY}, default width constants, and a saturating-increment function.
- Sub-module `rr_pick`: purely combinational. Inputs are req[N_PORTS] and last; outputs are a winner index and any.
- The FSM, output register and orphan counter live in pkt_tx_arbiter.

## Test plan
- Single packet on port 3: 5 beats, last beat empty=5. Expect 5 output beats with channel=3, sop on beat 1, eop on beat 5, empty=5, and first out_valid 2 cycles after the request.
- Ports 0–3 all request simultaneously, 2-beat packets each, with last=3 after reset. Grant order must be 0,1,2,3, and each packet must be contiguous.
- Port 1 requests twice back-to-back while port 2 waits. Order must be 1,2,1, with one idle cycle between packets.
- Random out_ready (50%) during an 8-beat packet. The output sequence must equal the input sequence exactly, and out_* must hold during every stall.
- Orphan handling: port 2 sends valid without sop for 3 cycles while IDLE. Expect orphan_count=3, three err_orphan pulses, and no output beats. Force the count to 0xFFFE and inject 3 orphans; it must stop at 0xFFFF.
- Assert reset_n low during beat 3 of a 6-beat packet. All outputs must be 0 immediately. After release, a new port-0 packet must be forwarded normally.
